// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM encoding, wait-counter width and the stage-control bundle.
package hazard_ctrl_pkg;

  localparam int WCNT_W = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_src;
    logic mem_stall;
  } ctrl_t;

  // The zero register is hard-wired, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(
    input logic       idex_mem_read,
    input logic [4:0] idex_rt,
    input logic [4:0] ifid_rs,
    input logic [4:0] ifid_rt
  );
    return idex_mem_read && (idex_rt != REG_ZERO) &&
           ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// One-cycle update latency; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush, load-use bubble.
// Controls are combinational in the same cycle; counters update on the following edge.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             Clk_in,
  input  logic             Rst_n_in,
  input  logic             IDEX_MemRead_in,
  input  logic [4:0]       IDEX_Rt_in,
  input  logic [4:0]       IFID_Rs_in,
  input  logic [4:0]       IFID_Rt_in,
  input  logic             EXMEM_MemRead_in,
  input  logic             EXMEM_MemWrite_in,
  input  logic             EXMEM_Branch_in,
  input  logic             EXMEM_Zero_in,
  output logic             PCWrite_out,
  output logic             IFIDWrite_out,
  output logic             IDEXWrite_out,
  output logic             EXMEMWrite_out,
  output logic             IFIDFlush_out,
  output logic             IDEXFlush_out,
  output logic             EXMEMFlush_out,
  output logic             PCSrc_out,
  output logic             MemStall_out,
  output logic [CNT_W-1:0] StallCount_out,
  output logic [CNT_W-1:0] FlushCount_out
);

  localparam bit HAS_WAIT = (MEM_LAT > 0);
  // The RUN freeze cycle is the first of MEM_LAT stall cycles, so the counter starts one short.
  localparam logic [WCNT_W-1:0] WAIT_INIT = (MEM_LAT > 0) ? WCNT_W'(MEM_LAT - 1) : '0;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  ctrl_t             ctrl;

  logic taken, mem_acc, load_use, freeze;
  logic stall_inc, flush_inc;

  assign taken    = EXMEM_Branch_in & EXMEM_Zero_in;
  assign mem_acc  = EXMEM_MemRead_in | EXMEM_MemWrite_in;
  assign load_use = load_use_hit(IDEX_MemRead_in, IDEX_Rt_in, IFID_Rs_in, IFID_Rt_in);
  assign freeze   = (state == RUN) ? (HAS_WAIT && mem_acc) : (wcnt != '0);

  always_ff @(posedge Clk_in) begin
    if (!Rst_n_in) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    ctrl      = '0;
    state_nxt = state;
    wcnt_nxt  = wcnt;
    if (!Rst_n_in) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
      state_nxt        = RUN;
      wcnt_nxt         = '0;
    end else if (freeze) begin
      ctrl.mem_stall = 1'b1;
      if (state == RUN) begin
        state_nxt = MEM_WAIT;
        wcnt_nxt  = WAIT_INIT;
      end else begin
        wcnt_nxt = wcnt - WCNT_W'(1);
      end
    end else begin
      state_nxt        = RUN;
      ctrl.pc_write    = 1'b1;
      ctrl.ifid_write  = 1'b1;
      ctrl.idex_write  = 1'b1;
      ctrl.exmem_write = 1'b1;
      if (taken) begin
        ctrl.pc_src      = 1'b1;
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_flush  = 1'b1;
        ctrl.exmem_flush = 1'b1;
      end else if (load_use) begin
        ctrl.pc_write   = 1'b0;
        ctrl.ifid_write = 1'b0;
        ctrl.idex_flush = 1'b1;
      end
    end
  end

  assign PCWrite_out    = ctrl.pc_write;
  assign IFIDWrite_out  = ctrl.ifid_write;
  assign IDEXWrite_out  = ctrl.idex_write;
  assign EXMEMWrite_out = ctrl.exmem_write;
  assign IFIDFlush_out  = ctrl.ifid_flush;
  assign IDEXFlush_out  = ctrl.idex_flush;
  assign EXMEMFlush_out = ctrl.exmem_flush;
  assign PCSrc_out      = ctrl.pc_src;
  assign MemStall_out   = ctrl.mem_stall;

  assign stall_inc = Rst_n_in & ~ctrl.pc_write & ~ctrl.pc_src;
  assign flush_inc = Rst_n_in & ctrl.pc_src;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (Clk_in),
    .clr_n (Rst_n_in),
    .inc   (stall_inc),
    .count (StallCount_out)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (Clk_in),
    .clr_n (Rst_n_in),
    .inc   (flush_inc),
    .count (FlushCount_out)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance a uses MEM_LAT=2, instance b uses MEM_LAT=4.
module tb_hazard_ctrl;

  // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, EXMEMFlush, PCSrc, MemStall}
  localparam logic [8:0] C_RST = 9'b0000_111_0_0;
  localparam logic [8:0] C_RUN = 9'b1111_000_0_0;
  localparam logic [8:0] C_LU  = 9'b0011_010_0_0;
  localparam logic [8:0] C_TK  = 9'b1111_111_1_0;
  localparam logic [8:0] C_FRZ = 9'b0000_000_0_1;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       idex_mr;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       exm_mr, exm_mw, exm_br, exm_z;

  logic        pcw_a, ifidw_a, idexw_a, exmw_a, ifidf_a, idexf_a, exmf_a, pcsrc_a, mst_a;
  logic        pcw_b, ifidw_b, idexw_b, exmw_b, ifidf_b, idexf_b, exmf_b, pcsrc_b, mst_b;
  logic [15:0] stall_a, flush_a, stall_b, flush_b;
  logic [8:0]  ctrl_a, ctrl_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctrl_a = {pcw_a, ifidw_a, idexw_a, exmw_a, ifidf_a, idexf_a, exmf_a, pcsrc_a, mst_a};
  assign ctrl_b = {pcw_b, ifidw_b, idexw_b, exmw_b, ifidf_b, idexf_b, exmf_b, pcsrc_b, mst_b};

  hazard_ctrl #(.MEM_LAT(2), .CNT_W(16)) dut_a (
    .Clk_in(clk), .Rst_n_in(rst_a),
    .IDEX_MemRead_in(idex_mr), .IDEX_Rt_in(idex_rt),
    .IFID_Rs_in(ifid_rs), .IFID_Rt_in(ifid_rt),
    .EXMEM_MemRead_in(exm_mr), .EXMEM_MemWrite_in(exm_mw),
    .EXMEM_Branch_in(exm_br), .EXMEM_Zero_in(exm_z),
    .PCWrite_out(pcw_a), .IFIDWrite_out(ifidw_a), .IDEXWrite_out(idexw_a),
    .EXMEMWrite_out(exmw_a), .IFIDFlush_out(ifidf_a), .IDEXFlush_out(idexf_a),
    .EXMEMFlush_out(exmf_a), .PCSrc_out(pcsrc_a), .MemStall_out(mst_a),
    .StallCount_out(stall_a), .FlushCount_out(flush_a)
  );

  hazard_ctrl #(.MEM_LAT(4), .CNT_W(16)) dut_b (
    .Clk_in(clk), .Rst_n_in(rst_b),
    .IDEX_MemRead_in(idex_mr), .IDEX_Rt_in(idex_rt),
    .IFID_Rs_in(ifid_rs), .IFID_Rt_in(ifid_rt),
    .EXMEM_MemRead_in(exm_mr), .EXMEM_MemWrite_in(exm_mw),
    .EXMEM_Branch_in(exm_br), .EXMEM_Zero_in(exm_z),
    .PCWrite_out(pcw_b), .IFIDWrite_out(ifidw_b), .IDEXWrite_out(idexw_b),
    .EXMEMWrite_out(exmw_b), .IFIDFlush_out(ifidf_b), .IDEXFlush_out(idexf_b),
    .EXMEMFlush_out(exmf_b), .PCSrc_out(pcsrc_b), .MemStall_out(mst_b),
    .StallCount_out(stall_b), .FlushCount_out(flush_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    idex_mr = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    exm_mr = 1'b0; exm_mw = 1'b0; exm_br = 1'b0; exm_z = 1'b0;
    #1;
    chk("a_reset_ctrl", 32'(ctrl_a), 32'(C_RST));
    chk("b_reset_ctrl", 32'(ctrl_b), 32'(C_RST));
    tick;
    chk("a_reset_stall", 32'(stall_a), 32'd0);
    chk("a_reset_flush", 32'(flush_a), 32'd0);

    // Instance b: reset lands in the second MEM_WAIT cycle of a 4-cycle wait
    exm_mr = 1'b1; rst_b = 1'b1; #1;
    chk("b_run_freeze", 32'(ctrl_b), 32'(C_FRZ));
    chk("a_held_reset", 32'(ctrl_a), 32'(C_RST));
    tick;
    chk("b_wait1_ctrl", 32'(ctrl_b), 32'(C_FRZ));
    chk("b_wait1_stall", 32'(stall_b), 32'd1);
    tick;
    chk("b_wait2_ctrl", 32'(ctrl_b), 32'(C_FRZ));
    chk("b_wait2_stall", 32'(stall_b), 32'd2);
    rst_b = 1'b0; #1;
    chk("b_mid_reset_ctrl", 32'(ctrl_b), 32'(C_RST));
    tick;
    chk("b_mid_reset_stall", 32'(stall_b), 32'd0);
    chk("b_mid_reset_flush", 32'(flush_b), 32'd0);
    exm_mr = 1'b0; rst_b = 1'b1; #1;
    chk("b_release_run", 32'(ctrl_b), 32'(C_RUN));
    tick;
    rst_b = 1'b0;

    // Instance a: basic run
    rst_a = 1'b1; #1;
    chk("a_run_ctrl", 32'(ctrl_a), 32'(C_RUN));
    tick;
    chk("a_run_stall", 32'(stall_a), 32'd0);

    // Load-use on Rs
    idex_mr = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd0; #1;
    chk("lu_rs_ctrl", 32'(ctrl_a), 32'(C_LU));
    tick;
    chk("lu_rs_stall", 32'(stall_a), 32'd1);
    idex_mr = 1'b0; #1;
    chk("lu_bubble_run", 32'(ctrl_a), 32'(C_RUN));
    tick;
    chk("lu_bubble_stall", 32'(stall_a), 32'd1);

    // Load-use on Rt
    idex_mr = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd0; ifid_rt = 5'd5; #1;
    chk("lu_rt_ctrl", 32'(ctrl_a), 32'(C_LU));
    tick;
    chk("lu_rt_stall", 32'(stall_a), 32'd2);

    // Register zero and non-matching registers never stall
    idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; #1;
    chk("lu_reg0_ctrl", 32'(ctrl_a), 32'(C_RUN));
    tick;
    chk("lu_reg0_stall", 32'(stall_a), 32'd2);
    idex_rt = 5'd3; ifid_rs = 5'd4; ifid_rt = 5'd6; #1;
    chk("lu_nomatch_ctrl", 32'(ctrl_a), 32'(C_RUN));
    idex_mr = 1'b0;

    // Load access: two freeze cycles then advance
    exm_mr = 1'b1; #1;
    chk("ld_freeze1", 32'(ctrl_a), 32'(C_FRZ));
    tick;
    chk("ld_freeze2", 32'(ctrl_a), 32'(C_FRZ));
    chk("ld_stall1", 32'(stall_a), 32'd3);
    tick;
    chk("ld_advance", 32'(ctrl_a), 32'(C_RUN));
    chk("ld_stall2", 32'(stall_a), 32'd4);
    tick;
    exm_mr = 1'b0;
    chk("ld_stall_final", 32'(stall_a), 32'd4);

    // Store access whose advance cycle sees a taken branch
    exm_mw = 1'b1; #1;
    chk("st_freeze1", 32'(ctrl_a), 32'(C_FRZ));
    tick;
    chk("st_freeze2", 32'(ctrl_a), 32'(C_FRZ));
    tick;
    chk("st_stall", 32'(stall_a), 32'd6);
    exm_br = 1'b1; exm_z = 1'b1; #1;
    chk("st_advance_taken", 32'(ctrl_a), 32'(C_TK));
    tick;
    exm_mw = 1'b0;
    chk("st_taken_flush", 32'(flush_a), 32'd1);
    chk("st_taken_stall", 32'(stall_a), 32'd6);

    // Taken beats load-use
    idex_mr = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd0; #1;
    chk("tk_lu_ctrl", 32'(ctrl_a), 32'(C_TK));
    tick;
    chk("tk_lu_flush", 32'(flush_a), 32'd2);
    chk("tk_lu_stall", 32'(stall_a), 32'd6);
    idex_mr = 1'b0; exm_z = 1'b0; #1;
    chk("branch_only", 32'(ctrl_a), 32'(C_RUN));
    exm_br = 1'b0; exm_z = 1'b1; #1;
    chk("zero_only", 32'(ctrl_a), 32'(C_RUN));

    // Memory freeze beats taken
    exm_mr = 1'b1; exm_br = 1'b1; exm_z = 1'b1; #1;
    chk("frz_over_tk", 32'(ctrl_a), 32'(C_FRZ));
    tick;
    chk("frz_over_tk_wait", 32'(ctrl_a), 32'(C_FRZ));
    tick;
    chk("frz_over_tk_adv", 32'(ctrl_a), 32'(C_TK));
    chk("frz_over_tk_stall", 32'(stall_a), 32'd8);
    tick;
    chk("frz_over_tk_flush", 32'(flush_a), 32'd3);
    exm_mr = 1'b0; exm_br = 1'b0; exm_z = 1'b0;

    // Reset clears counters and blocks counting of a pending load-use
    rst_a = 1'b0; idex_mr = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd0; #1;
    chk("a_rst2_ctrl", 32'(ctrl_a), 32'(C_RST));
    tick;
    tick;
    chk("a_rst2_stall", 32'(stall_a), 32'd0);
    chk("a_rst2_flush", 32'(flush_a), 32'd0);

    // Saturation after 65535 stall cycles
    rst_a = 1'b1; #1;
    chk("sat_lu_ctrl", 32'(ctrl_a), 32'(C_LU));
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_reach", 32'(stall_a), 32'h0000_FFFF);
    chk("sat_ctrl", 32'(ctrl_a), 32'(C_LU));
    tick;
    chk("sat_hold", 32'(stall_a), 32'h0000_FFFF);
    chk("sat_flush", 32'(flush_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 2, data-memory wait cycles per load/store (legal 0..15).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 Clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n_in  input  1  reset, synchronous, active-low.
REQ-005 IDEX_MemRead_in  input  1  load in ID/EX.
REQ-006 IDEX_Rt_in  input  5  destination register of ID/EX load.
REQ-007 IFID_Rs_in, IFID_Rt_in  input  5 each  source registers of the instruction in IF/ID.
REQ-008 EXMEM_MemRead_in, EXMEM_MemWrite_in  input  1 each  memory access in EX/MEM.
REQ-009 EXMEM_Branch_in, EXMEM_Zero_in  input  1 each  branch and zero flag in EX/MEM.
REQ-010 PCWrite_out, IFIDWrite_out, IDEXWrite_out, EXMEMWrite_out  output  1 each  stage load enables.
REQ-011 IFIDFlush_out, IDEXFlush_out, EXMEMFlush_out  output  1 each  load bubble (all controls 0) into stage.
REQ-012 PCSrc_out  output  1  select branch target for PC.
REQ-013 MemStall_out  output  1  high while a memory wait is in progress.
REQ-014 StallCount_out, FlushCount_out  output  CNT_W each  performance counters.

Function
REQ-015 Definitions: Taken = EXMEM_Branch_in & EXMEM_Zero_in; MemAcc = EXMEM_MemRead_in | EXMEM_MemWrite_in; LoadUse = IDEX_MemRead_in & IDEX_Rt_in!=0 & (IDEX_Rt_in==IFID_Rs_in | IDEX_Rt_in==IFID_Rt_in).
REQ-016 FSM states RUN and MEM_WAIT; 4-bit wait counter wcnt; outputs combinational from state, wcnt and inputs.
REQ-017 RUN with MemAcc and MEM_LAT>0: freeze cycle -- all four write enables 0, all flushes 0, PCSrc_out 0, MemStall_out 1; next state MEM_WAIT, wcnt <= MEM_LAT-1.
REQ-018 MEM_WAIT with wcnt>0: freeze outputs as REQ-017; wcnt decrements; inputs ignored.
REQ-019 MEM_WAIT with wcnt==0: advance cycle, outputs per REQ-020..022; next state RUN.
REQ-020 Advance cycle (RUN without freeze, or REQ-019) with Taken: PCSrc_out 1, all write enables 1, IFIDFlush_out, IDEXFlush_out, EXMEMFlush_out 1.
REQ-021 Advance cycle with LoadUse and not Taken: PCWrite_out 0, IFIDWrite_out 0, IDEXFlush_out 1, other enables 1, other flushes 0; exactly one bubble per load-use pair.
REQ-022 Advance cycle otherwise: all write enables 1, all flushes 0, PCSrc_out 0.
REQ-023 Priority: memory freeze > Taken > LoadUse.
REQ-024 Total stall per memory access is exactly MEM_LAT cycles; MEM_LAT==0 never enters MEM_WAIT.
REQ-025 StallCount_out increments on each non-reset cycle with PCWrite_out==0 and PCSrc_out==0; saturates at all-ones.
REQ-026 FlushCount_out increments on each cycle with PCSrc_out==1; saturates at all-ones.
REQ-027 Register 0 never causes a load-use stall.

Reset
REQ-028 On rising edge with Rst_n_in low: state RUN, wcnt 0, both counters 0.
REQ-029 While Rst_n_in low: all write enables 0, all flushes 1, PCSrc_out 0, MemStall_out 0; counters do not increment.
REQ-030 Reset asserted in MEM_WAIT abandons the wait; first cycle after release evaluates RUN rules.

Structure
REQ-031 Shared package hazard_ctrl_pkg holds state encoding (RUN=0, MEM_WAIT=1), wait-counter width 4, and REG_ZERO constant 5'd0.
REQ-032 One sub-module sat_counter (CNT_W-bit, synchronous active-low clear, increment enable, saturating) instantiated twice.

Verification
REQ-033 IDEX load Rt=8, IFID Rs=8, no branch/MemAcc -> one cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; StallCount 0->1.
REQ-034 MEM_LAT=2, EXMEM_MemRead=1 in RUN -> 2 freeze cycles (MemStall=1, enables 0) then advance; StallCount +2.
REQ-035 Taken=1 coinciding with LoadUse=1 -> PCSrc=1, three flushes 1, PCWrite=1; FlushCount +1, StallCount unchanged.
REQ-036 IDEX load Rt=0, IFID Rs=0 -> no stall, all enables 1.
REQ-037 Rst_n_in low during second MEM_WAIT cycle (MEM_LAT=4) -> enables 0, flushes 1; after release state RUN, counters 0.
REQ-038 Force StallCount to all-ones via 65535 load-use stalls (CNT_W=16) -> further stall holds 16'hFFFF.
